rv32_fetch_buffer: RTL and testbench

//  Parametrised instruction-fetch front end replacing the fixed single-entry IF/ID queue.

---
 rtl/rv32_fetch_buffer.sv | 124 ++++++++++++
 tb/tb_rv32_fetch_buffer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/rv32_fetch_buffer.sv
// rtl/rv32_fetch_buffer.sv - instruction fetch front end with PC tracking and DEPTH-entry word FIFO
module rv32_fetch_buffer #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [XLEN-1:0]          pc_fetch,
    output logic                     fetch_req,
    input  logic [XLEN-1:0]          code_fetch,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     out_valid,
    output logic [XLEN-1:0]          out_code,
    output logic [XLEN-1:0]          out_pc,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]   DEPTH_CREDIT = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_OCC    = CW'(DEPTH);

    logic [XLEN-1:0] mem_code [DEPTH];
    logic [XLEN-1:0] mem_pc   [DEPTH];

    logic [XLEN-1:0] pc_fetch_q, pc_fetch_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic            inflight_q, inflight_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   occ_q, occ_d;
    logic [XLEN-1:0] out_code_q, out_code_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;

    logic [CW:0] credit;
    logic        issue;
    logic        push;
    logic        pop;

    // A request is only issued when a FIFO slot is guaranteed for its response.
    assign credit    = {1'b0, occ_q} + {{CW{1'b0}}, inflight_q};
    assign issue     = rst_n & ~redirect_valid & (credit < DEPTH_CREDIT);
    assign push      = inflight_q & ~redirect_valid;
    assign out_valid = (occ_q != '0);
    assign pop       = out_valid & out_ready & ~redirect_valid;

    assign fetch_req = issue;
    assign pc_fetch  = pc_fetch_q;
    assign occupancy = occ_q;
    assign out_code  = out_code_q;
    assign out_pc    = out_pc_q;

    always_comb begin
        pc_fetch_d = pc_fetch_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        out_code_d = out_code_q;
        out_pc_d   = out_pc_q;
        if (redirect_valid) begin
            pc_fetch_d = redirect_pc & ~XLEN'(3);
            inflight_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            occ_d      = '0;
        end else begin
            inflight_d = issue;
            if (issue) begin
                pc_fetch_d = pc_fetch_q + XLEN'(4);
                resp_pc_d  = pc_fetch_q;
            end
            wr_ptr_d = wr_ptr_q + AW'(push);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            occ_d    = occ_q + CW'(push) - CW'(pop);
            // Head registers track the entry that will sit at rd_ptr after this edge.
            if (occ_d != '0) begin
                if (push && (wr_ptr_q == rd_ptr_d)) begin
                    out_code_d = code_fetch;
                    out_pc_d   = resp_pc_q;
                end else begin
                    out_code_d = mem_code[rd_ptr_d];
                    out_pc_d   = mem_pc[rd_ptr_d];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_fetch_q <= RESET_PC;
            resp_pc_q  <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            out_code_q <= '0;
            out_pc_q   <= '0;
        end else begin
            pc_fetch_q <= pc_fetch_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            out_code_q <= out_code_d;
            out_pc_q   <= out_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_code[wr_ptr_q] <= code_fetch;
            mem_pc[wr_ptr_q]   <= resp_pc_q;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (occ_q == DEPTH_OCC)));

endmodule

// File: tb/tb_rv32_fetch_buffer.sv
// tb/tb_rv32_fetch_buffer.sv - self-checking bench for rv32_fetch_buffer
module tb_rv32_fetch_buffer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_fetch;
    logic        fetch_req;
    logic [31:0] code_fetch = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic [31:0] out_code;
    logic [31:0] out_pc;
    logic        out_ready = 1'b0;
    logic [2:0]  occupancy;

    int total = 0;
    int bad = 0;

    rv32_fetch_buffer #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .pc_fetch(pc_fetch), .fetch_req(fetch_req),
        .code_fetch(code_fetch), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_code(out_code), .out_pc(out_pc),
        .out_ready(out_ready), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Synchronous code memory: word equals its address.
    always @(posedge clk) if (fetch_req) code_fetch <= pc_fetch;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard: expected PCs queued at issue, dropped on flush, compared on pop.
    logic [31:0] sbq[$];
    logic [31:0] model_pc = 32'h0;
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst_n) begin
            sbq.delete();
            model_pc = 32'h0;
        end else if (redirect_valid) begin
            sbq.delete();
            model_pc = redirect_pc & ~32'h3;
        end else begin
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 32'h1, 32'h0);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_out_pc", out_pc, e);
                    chk("sb_out_code", out_code, e);
                end
            end
            if (fetch_req) begin
                chk("sb_pc_fetch", pc_fetch, model_pc);
                sbq.push_back(model_pc);
                model_pc = model_pc + 32'h4;
            end
        end
    end

    task automatic wait_out(input logic [31:0] exp, input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                chk(name, out_pc, exp);
                return;
            end
        end
        chk({name, "_timeout"}, 32'h1, 32'h0);
    endtask

    typedef struct {
        logic        rst_n;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        int          n;
        logic        e_valid;
        logic [2:0]  e_occ;
        logic        e_req;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 32'h0,   1'b0, 2, 1'b0, 3'd0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1, 1'b0, 3'd0, 1'b1, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1, 1'b0, 3'd0, 1'b1, 32'h4};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1, 1'b1, 3'd1, 1'b1, 32'h8};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,   1'b0, 4, 1'b1, 3'd4, 1'b0, 32'h10};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1, 1'b1, 3'd4, 1'b0, 32'h10};
        vecs[6]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1, 1'b1, 3'd3, 1'b1, 32'h10};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1, 1'b1, 3'd2, 1'b1, 32'h14};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1, 1'b1, 3'd2, 1'b1, 32'h18};
        vecs[9]  = '{1'b1, 1'b1, 32'h103, 1'b1, 1, 1'b1, 3'd2, 1'b0, 32'h1C};
        vecs[10] = '{1'b1, 1'b0, 32'h0,   1'b1, 1, 1'b0, 3'd0, 1'b1, 32'h100};
        vecs[11] = '{1'b1, 1'b0, 32'h0,   1'b1, 1, 1'b0, 3'd0, 1'b1, 32'h104};
        vecs[12] = '{1'b1, 1'b0, 32'h0,   1'b1, 1, 1'b1, 3'd1, 1'b1, 32'h108};

        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #2;
            rst_n = vecs[i].rst_n;
            redirect_valid = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            out_ready = vecs[i].ready;
            repeat (vecs[i].n - 1) @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_valid});
            chk($sformatf("v%0d_occ", i), {29'b0, occupancy}, {29'b0, vecs[i].e_occ});
            chk($sformatf("v%0d_req", i), {31'b0, fetch_req}, {31'b0, vecs[i].e_req});
            chk($sformatf("v%0d_pc_fetch", i), pc_fetch, vecs[i].e_pc);
        end

        // Redirect while full and popping.
        @(posedge clk); #2; out_ready = 1'b0;
        repeat (8) @(posedge clk);
        #2; out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h103;
        @(posedge clk); #2; redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir_valid_drop", {31'b0, out_valid}, 32'h0);
        chk("redir_occ_clear", {29'b0, occupancy}, 32'h0);
        wait_out(32'h100, "redir_first");
        wait_out(32'h104, "redir_second");

        // Back-to-back redirects: only the last target is fetched.
        @(posedge clk); #2; redirect_valid = 1'b1; redirect_pc = 32'h200;
        @(posedge clk); #2; redirect_pc = 32'h300;
        @(posedge clk); #2; redirect_valid = 1'b0;
        wait_out(32'h300, "b2b_first");

        // Address wrap at the top of the space.
        @(posedge clk); #2; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        @(posedge clk); #2; redirect_valid = 1'b0;
        wait_out(32'hFFFF_FFF8, "wrap_0");
        wait_out(32'hFFFF_FFFC, "wrap_1");
        wait_out(32'h0000_0000, "wrap_2");
        wait_out(32'h0000_0004, "wrap_3");

        // Asynchronous reset with a full FIFO.
        @(posedge clk); #2; out_ready = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_full", {29'b0, occupancy}, 32'h4);
        @(posedge clk); #2; rst_n = 1'b0;
        #1;
        chk("reset_valid", {31'b0, out_valid}, 32'h0);
        chk("reset_occ", {29'b0, occupancy}, 32'h0);
        chk("reset_req", {31'b0, fetch_req}, 32'h0);
        chk("reset_pc", pc_fetch, 32'h0);
        @(posedge clk); #2; rst_n = 1'b1; out_ready = 1'b1;
        wait_out(32'h0, "restart_0");
        wait_out(32'h4, "restart_1");

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
